bus_rr_arbiter: RTL
===================

Name: bus_rr_arbiter

Overview:
Round-robin arbiter that shares the 4-bit transfer bus between four sources (A, B, C, D).
- Owns the 2-bit mux select and registered one-hot grants.
- Enforces a maximum tenure per owner so no source can hold the bus indefinitely.
- Drives the bus through a per-bit 4:1 mux slice array; the bus is zero whenever nobody owns it.

Parameters:
WIDTH, 4, bus and source data width in bits
MAX_HOLD, 8, maximum consecutive cycles one owner keeps the bus while another request is pending (legal range 2..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D
a  input  WIDTH  source A data
b  input  WIDTH  source B data
c  input  WIDTH  source C data
d  input  WIDTH  source D data
grant  output  4  one-hot registered grant, same bit order as req
sel  output  2  registered mux select {x,y}: A=00, B=01, C=10, D=11
bus_valid  output  1  registered; 1 while an owner holds the bus
bus  output  WIDTH  data of the selected source when bus_valid=1, else all zeros

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a rising edge):
  - grant=0000, sel=00, bus_valid=0, bus=0.
  - state=IDLE, hold_cnt=0, last_owner=D, so A has first priority after reset.
  - Reset mid-tenure drops the grant on that edge; no completion is owed.
- States:
  - IDLE: no owner.
  - BUSY: grant has exactly one bit set.
- Priority: search starts at last_owner+1 (mod 4) and takes the first asserted req.
- IDLE -> BUSY: if any req bit is set at an edge, that edge registers grant, sel, bus_valid=1 and hold_cnt=0, and sets last_owner to the winner.
  - Latency: req high before edge N gives grant visible after edge N (1 cycle).
- BUSY, owner req still high:
  - Other reqs pending and hold_cnt==MAX_HOLD-1: hand off on this edge to the next RR winner among the others; hold_cnt=0.
  - Other reqs pending and hold_cnt<MAX_HOLD-1: keep the owner; hold_cnt+1.
  - No other req: keep the owner; hold_cnt saturates at MAX_HOLD-1.
  - Consequence: a late arrival is granted at the very next edge if the owner has already reached the limit.
- BUSY, owner req low at an edge:
  - Another req pending: hand off directly on the same edge (no idle bubble); hold_cnt=0.
  - Otherwise: go to IDLE with grant=0000 and bus_valid=0. sel keeps its last value.
- Tenure guarantee: with contention, an owner holds for at most MAX_HOLD cycles. Within any 4 handoffs, every persistently requesting source is served.
- Owner drop and other arrivals on the same edge: arrivals are considered, and the RR order starts after the departing owner.
- Bus output:
  - bus is combinational from the registered sel and bus_valid, plus the current source data.
  - Per bit: bus[i] = mux(a[i],b[i],c[i],d[i]) selected by sel, ANDed with bus_valid.
- Invariants (assertions): grant is one-hot or zero; grant!=0 iff bus_valid; when bus_valid=1, sel equals the encoded grant index.

Decomposition:
- Shared package:
  - State encoding IDLE/BUSY.
  - Source index constants SRC_A=0, SRC_B=1, SRC_C=2, SRC_D=3.
  - Select encodings SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
- Sub-module bus_mux_slice: a 1-bit 4:1 gate-level mux with an enable input, instantiated WIDTH times for the bus datapath.
- Arbiter FSM, RR search and hold counter all stay in the top module.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req=1111 -> grant=0000, sel=00, bus_valid=0, bus=0000. Release with req=1111 -> after first edge grant=0001, sel=00, bus=a.
2. Single requester: a=0000, b=0001, c=1000, d=1111; req=0100 held 20 cycles -> grant=0100, sel=10, bus=1000 every cycle, no handoff. Drop req -> next edge grant=0000, bus=0000.
3. Round-robin fairness: MAX_HOLD=8, req=1111 constant -> grants rotate 0001,0010,0100,1000,0001; each held exactly 8 cycles; bus follows 0000,0001,1000,1111.
4. Early release handoff: B owns the bus; req changes from 0010 to 1001 at one edge -> that edge grants 1000 (D, first after B in RR order), with no IDLE cycle; bus=1111.
5. Late arrival after saturation: A alone for 12 cycles; then req=0011 -> at the next edge grant=0010, sel=01, bus=0001.
6. Reset mid-tenure: C owns the bus with hold_cnt=3; rst_n=0 for one edge -> grant=0000, bus_valid=0. With req=0100 after release -> grant=0100 one edge later, hold_cnt restarts at 0.

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding,
// source index / select constants and the round-robin search helper.
package bus_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned SRC_A = 0;
   localparam int unsigned SRC_B = 1;
   localparam int unsigned SRC_C = 2;
   localparam int unsigned SRC_D = 3;

   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;

   // Returns {found, index}. The search starts at last+1 and wraps, so the
   // nearest requester after 'last' wins; 'last' itself is checked last.
   function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = '0;
      // Walk from farthest to nearest so the nearest hit overwrites.
      for (int unsigned k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Bus interface between the four sources and the arbiter.
//   req        : per-source request (bit0=A .. bit3=D)
//   a,b,c,d    : source data
//   grant      : one-hot registered grant
//   sel        : registered mux select (A=00 .. D=11)
//   bus_valid  : an owner holds the bus
//   bus        : selected source data, zero when bus_valid=0
// master = source side, slave = arbiter side.
interface bus_rr_arbiter_if #(
   parameter int unsigned WIDTH = 4
);
   logic [3:0]       req;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [3:0]       grant;
   logic [1:0]       sel;
   logic             bus_valid;
   logic [WIDTH-1:0] bus;

   modport master (
      output req, a, b, c, d,
      input  grant, sel, bus_valid, bus
   );

   modport slave (
      input  req, a, b, c, d,
      output grant, sel, bus_valid, bus
   );
endinterface

// File: rtl/bus_rr_arbiter_mux_slice.sv
// One bit of the bus datapath: gate-level 4:1 mux gated by an enable.
//   d0_i..d3_i : candidate bits (A..D)
//   sel_i      : select {x,y}
//   en_i       : output forced low when 0
//   y_o        : selected bit
module bus_mux_slice (
   input  logic       d0_i,
   input  logic       d1_i,
   input  logic       d2_i,
   input  logic       d3_i,
   input  logic [1:0] sel_i,
   input  logic       en_i,
   output logic       y_o
);
   logic s1_n, s0_n;
   logic t0, t1, t2, t3;

   assign s1_n = ~sel_i[1];
   assign s0_n = ~sel_i[0];
   assign t0   = s1_n     & s0_n     & d0_i;
   assign t1   = s1_n     & sel_i[0] & d1_i;
   assign t2   = sel_i[1] & s0_n     & d2_i;
   assign t3   = sel_i[1] & sel_i[0] & d3_i;
   assign y_o  = en_i & (t0 | t1 | t2 | t3);
endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing the transfer bus between sources A..D with a
// bounded tenure per owner.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   arb    : slave side of bus_rr_arbiter_if (req/data in, grant/sel/
//            bus_valid/bus out)
module bus_rr_arbiter
   import bus_rr_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bus_rr_arbiter_if.slave       arb
);

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   arb_state_e       state_q;
   logic [3:0]       grant_q;
   logic [1:0]       sel_q;
   logic             valid_q;
   logic [7:0]       hold_cnt_q;
   logic [1:0]       last_q;

   logic [3:0]       cand_d;
   logic [2:0]       pick_d;
   logic             win_vld_d;
   logic [1:0]       win_idx_d;
   logic             owner_req_d;
   logic [WIDTH-1:0] bus_d;

   // While busy the owner is excluded so a handoff always goes elsewhere;
   // last_q is the current owner, so the search order starts after it.
   always_comb begin
      cand_d = arb.req;
      if (state_q == ST_BUSY) cand_d = arb.req & ~idx_onehot(last_q);
   end

   assign pick_d      = rr_pick(cand_d, last_q);
   assign win_vld_d   = pick_d[2];
   assign win_idx_d   = pick_d[1:0];
   assign owner_req_d = arb.req[last_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         sel_q      <= SEL_A;
         valid_q    <= 1'b0;
         hold_cnt_q <= '0;
         last_q     <= SEL_D;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_vld_d) begin
                  state_q    <= ST_BUSY;
                  grant_q    <= idx_onehot(win_idx_d);
                  sel_q      <= win_idx_d;
                  valid_q    <= 1'b1;
                  hold_cnt_q <= '0;
                  last_q     <= win_idx_d;
               end
            end
            ST_BUSY: begin
               if (!owner_req_d) begin
                  if (win_vld_d) begin
                     grant_q    <= idx_onehot(win_idx_d);
                     sel_q      <= win_idx_d;
                     hold_cnt_q <= '0;
                     last_q     <= win_idx_d;
                  end else begin
                     state_q    <= ST_IDLE;
                     grant_q    <= '0;
                     valid_q    <= 1'b0;
                     hold_cnt_q <= '0;
                  end
               end else if (win_vld_d) begin
                  if (hold_cnt_q >= HOLD_LIM) begin
                     grant_q    <= idx_onehot(win_idx_d);
                     sel_q      <= win_idx_d;
                     hold_cnt_q <= '0;
                     last_q     <= win_idx_d;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 8'd1;
                  end
               end else if (hold_cnt_q < HOLD_LIM) begin
                  // Saturating so a late arrival can take over immediately.
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_mux
      bus_mux_slice u_slice (
         .d0_i  (arb.a[i]),
         .d1_i  (arb.b[i]),
         .d2_i  (arb.c[i]),
         .d3_i  (arb.d[i]),
         .sel_i (sel_q),
         .en_i  (valid_q),
         .y_o   (bus_d[i])
      );
   end

   assign arb.grant     = grant_q;
   assign arb.sel       = sel_q;
   assign arb.bus_valid = valid_q;
   assign arb.bus       = bus_d;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant_q));
   a_grant_valid : assert property (@(posedge clk) disable iff (!rst_n)
      ((grant_q != 4'b0000) == valid_q));
   a_sel_matches : assert property (@(posedge clk) disable iff (!rst_n)
      (valid_q |-> grant_q[sel_q]));

endmodule
